// File: rtl/pe_mac_accum.sv
// Multi-lane multiply-accumulate processing element: capture, lane products,
// tree sum, then group accumulation with a saturating output register.
module pe_mac_accum #(
  parameter int DW    = 8,
  parameter int N     = 9,
  parameter int OUT_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic              signed_mode,
  input  logic [N*DW-1:0]   a_vec,
  input  logic [N*DW-1:0]   x_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  output logic              busy
);

  localparam int PW = 2 * DW;
  localparam int TW = PW + $clog2(N);
  localparam int AW = TW + 16;

  localparam logic [AW-1:0] ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] SMAX = (ONE << (OUT_W - 1)) - ONE;
  localparam logic [AW-1:0] SMIN = ~SMAX;
  localparam logic [AW-1:0] UMAX = (ONE << OUT_W) - ONE;

  logic stall;
  logic accept;
  logic beat_signed;

  logic grp_open;
  logic grp_signed;

  logic              s0_valid;
  logic              s0_last;
  logic              s0_signed;
  logic [N*DW-1:0]   s0_a;
  logic [N*DW-1:0]   s0_x;

  logic [N-1:0][PW-1:0] prod;
  logic              s1_valid;
  logic              s1_last;
  logic              s1_signed;
  logic [N-1:0][PW-1:0] s1_prod;

  logic [TW-1:0]     tree_sum;
  logic              s2_valid;
  logic              s2_last;
  logic              s2_signed;
  logic [TW-1:0]     s2_sum;

  logic [AW-1:0]     acc;
  logic [AW-1:0]     sum_ext;
  logic [AW-1:0]     final_sum;
  logic [OUT_W-1:0]  clamp_data;
  logic              clamp_sat;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;
  assign busy     = s0_valid || s1_valid || s2_valid || grp_open;

  // The first beat of a group fixes the mode; later beats inherit it.
  assign beat_signed = grp_open ? grp_signed : signed_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grp_open   <= 1'b0;
      grp_signed <= 1'b0;
    end else if (accept) begin
      grp_open   <= !in_last;
      grp_signed <= beat_signed;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid  <= 1'b0;
      s0_last   <= 1'b0;
      s0_signed <= 1'b0;
      s0_a      <= '0;
      s0_x      <= '0;
    end else if (!stall) begin
      s0_valid <= in_valid;
      if (in_valid) begin
        s0_last   <= in_last;
        s0_signed <= beat_signed;
        s0_a      <= a_vec;
        s0_x      <= x_vec;
      end
    end
  end

  function automatic logic [PW-1:0] ext_op(input logic [DW-1:0] v, input logic sgn);
    return {{DW{sgn & v[DW-1]}}, v};
  endfunction

  always_comb begin
    prod = '0;
    for (int i = 0; i < N; i++) begin
      prod[i] = ext_op(s0_a[i*DW +: DW], s0_signed) * ext_op(s0_x[i*DW +: DW], s0_signed);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_signed <= 1'b0;
      s1_prod   <= '0;
    end else if (!stall) begin
      s1_valid  <= s0_valid;
      s1_last   <= s0_last;
      s1_signed <= s0_signed;
      s1_prod   <= prod;
    end
  end

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < N; i++) begin
      tree_sum = tree_sum + {{(TW-PW){s1_signed & s1_prod[i][PW-1]}}, s1_prod[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      s2_signed <= 1'b0;
      s2_sum    <= '0;
    end else if (!stall) begin
      s2_valid  <= s1_valid;
      s2_last   <= s1_last;
      s2_signed <= s1_signed;
      s2_sum    <= tree_sum;
    end
  end

  assign sum_ext   = {{(AW-TW){s2_signed & s2_sum[TW-1]}}, s2_sum};
  assign final_sum = acc + sum_ext;

  always_comb begin
    clamp_data = final_sum[OUT_W-1:0];
    clamp_sat  = 1'b0;
    if (s2_signed) begin
      if ($signed(final_sum) > $signed(SMAX)) begin
        clamp_data = SMAX[OUT_W-1:0];
        clamp_sat  = 1'b1;
      end else if ($signed(final_sum) < $signed(SMIN)) begin
        clamp_data = SMIN[OUT_W-1:0];
        clamp_sat  = 1'b1;
      end
    end else if (final_sum > UMAX) begin
      clamp_data = UMAX[OUT_W-1:0];
      clamp_sat  = 1'b1;
    end
  end

  // Loading a new result and consuming the old one can share an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (!stall) begin
      out_valid <= 1'b0;
      if (s2_valid) begin
        if (s2_last) begin
          acc       <= '0;
          out_valid <= 1'b1;
          out_data  <= clamp_data;
          out_sat   <= clamp_sat;
        end else begin
          acc <= final_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_accum.sv
// Directed-vector bench for pe_mac_accum with hand-computed expected results.
module tb_pe_mac_accum;

  localparam int DW    = 8;
  localparam int N     = 9;
  localparam int OUT_W = 20;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic              signed_mode;
  logic [N*DW-1:0]   a_vec;
  logic [N*DW-1:0]   x_vec;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_sat;
  logic              busy;

  int vectors;
  int miscompares;

  logic [OUT_W-1:0] res_d;
  logic             res_s;

  pe_mac_accum #(.DW(DW), .N(N), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .signed_mode(signed_mode), .a_vec(a_vec), .x_vec(x_vec),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one beat with every lane equal, then returns just after its edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] x,
                               input logic sm, input logic last);
    for (int i = 0; i < N; i++) begin
      a_vec[i*DW +: DW] = a;
      x_vec[i*DW +: DW] = x;
    end
    in_valid    = 1'b1;
    signed_mode = sm;
    in_last     = last;
    @(posedge clk);
    #1;
  endtask

  task automatic goIdle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitResult(output logic [OUT_W-1:0] d, output logic s);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) checkOutput("result_timeout", 32'(out_valid), 32'd1);
    d = out_data;
    s = out_sat;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    signed_mode = 1'b0;
    a_vec       = '0;
    x_vec       = '0;
    out_ready   = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data",  32'(out_data),  32'd0);
    checkOutput("rst_out_sat",   32'(out_sat),   32'd0);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Unsigned full-scale single beat, with exact latency.
    applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b1);
    goIdle();
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("latency_edge%0d", k), 32'(out_valid), 32'(k == 3));
    end
    checkOutput("u_single_data", 32'(out_data), 32'd585225);
    checkOutput("u_single_sat",  32'(out_sat),  32'd0);

    // Two full-scale beats overflow the unsigned range.
    applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0);
    applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b1);
    goIdle();
    waitResult(res_d, res_s);
    checkOutput("u_clamp_data", 32'(res_d), 32'd1048575);
    checkOutput("u_clamp_sat",  32'(res_s), 32'd1);

    applyStimulus(8'hFF, 8'h02, 1'b1, 1'b1);
    goIdle();
    waitResult(res_d, res_s);
    checkOutput("s_single_data", 32'(res_d), 32'hFFFEE);
    checkOutput("s_single_sat",  32'(res_s), 32'd0);

    // Mode flips on beat 2; the group must stay signed.
    applyStimulus(8'hFF, 8'h02, 1'b1, 1'b0);
    applyStimulus(8'hFF, 8'h02, 1'b0, 1'b1);
    goIdle();
    waitResult(res_d, res_s);
    checkOutput("s_mode_hold_data", 32'(res_d), 32'hFFFDC);
    checkOutput("s_mode_hold_sat",  32'(res_s), 32'd0);

    // Four beats of -128*127 per lane: -585216 clamps to the signed minimum.
    for (int b = 0; b < 4; b++) applyStimulus(8'h80, 8'h7F, 1'b1, b == 3);
    goIdle();
    waitResult(res_d, res_s);
    checkOutput("s_clamp_data", 32'(res_d), 32'h80000);
    checkOutput("s_clamp_sat",  32'(res_s), 32'd1);

    // Backpressure: three single-beat groups while the sink is stalled.
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(8'd1, 8'd1, 1'b0, 1'b1);
    applyStimulus(8'd2, 8'd1, 1'b0, 1'b1);
    applyStimulus(8'd3, 8'd1, 1'b0, 1'b1);
    goIdle();
    @(posedge clk);
    #1;
    checkOutput("stall_valid",    32'(out_valid), 32'd1);
    checkOutput("stall_data",     32'(out_data),  32'd9);
    checkOutput("stall_in_ready", 32'(in_ready),  32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stall_hold_data",  32'(out_data), 32'd9);
    checkOutput("stall_hold_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("drain%0d_valid", k), 32'(out_valid), 32'd1);
      checkOutput($sformatf("drain%0d_data", k),  32'(out_data),  32'(9 * (k + 1)));
    end
    @(posedge clk);
    #1;
    checkOutput("drain_empty", 32'(out_valid), 32'd0);

    // Back-to-back single-beat groups with no stall: one result per cycle.
    applyStimulus(8'd5, 8'd1, 1'b0, 1'b1);
    applyStimulus(8'd6, 8'd1, 1'b0, 1'b1);
    applyStimulus(8'd7, 8'd1, 1'b0, 1'b1);
    goIdle();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("stream%0d_valid", k), 32'(out_valid), 32'd1);
      checkOutput($sformatf("stream%0d_data", k),  32'(out_data),  32'(9 * (5 + k)));
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Reset in the middle of an open group must leave no residue.
    applyStimulus(8'd50, 8'd50, 1'b0, 1'b0);
    applyStimulus(8'd50, 8'd50, 1'b0, 1'b0);
    goIdle();
    checkOutput("open_group_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_busy",  32'(busy),      32'd0);
    checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(8'd1, 8'd1, 1'b0, 1'b1);
    goIdle();
    waitResult(res_d, res_s);
    checkOutput("post_rst_data", 32'(res_d), 32'd9);
    checkOutput("post_rst_sat",  32'(res_s), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pe_mac_accum.md
PE_MAC_ACCUM -- requirements
Module: pe_mac_accum

Interface
REQ-001 SHALL have parameter DW, default 8: element width of A and X lanes.
REQ-002 SHALL have parameter N, default 9: multiply lanes per beat.
REQ-003 SHALL have parameter OUT_W, default 20: result width.
REQ-004 SHALL derive localparams PW=2*DW (product), TW=PW+clog2(N) (tree sum), AW=TW+16 (accumulator).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  beat present.
REQ-008 in_ready  output  1  beat accepted when in_valid&&in_ready at a rising edge.
REQ-009 in_last  input  1  accepted beat closes the current group.
REQ-010 signed_mode  input  1  1=two's-complement operands, 0=unsigned.
REQ-011 a_vec  input  N*DW  lane i at [i*DW +: DW].
REQ-012 x_vec  input  N*DW  lane i at [i*DW +: DW].
REQ-013 out_valid  output  1  result held in output register.
REQ-014 out_ready  input  1  result consumed when out_valid&&out_ready at a rising edge.
REQ-015 out_data  output  OUT_W  saturated group result.
REQ-016 out_sat  output  1  out_data was clamped.
REQ-017 busy  output  1  any pipeline stage valid or group open.

Function
REQ-018 SHALL implement three registered stages: S1 lane products, S2 adder-tree sum (TW bits), S3 accumulate/output.
REQ-019 S1 SHALL compute a_i*x_i, sign-extended when the group mode is signed, zero-extended otherwise.
REQ-020 Group mode SHALL be captured from signed_mode on the first beat of a group and travel with every beat of that group; mid-group changes SHALL be ignored.
REQ-021 S3 SHALL add each arriving tree sum to an AW-bit accumulator; accumulator wraps modulo 2^AW (groups up to 65536 beats are overflow-free).
REQ-022 When a last-flagged beat reaches S3, final = acc+sum SHALL be clamped into out_data, out_valid set, accumulator cleared in the same edge.
REQ-023 Clamp: signed to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; unsigned to [0, 2^OUT_W-1]; out_sat=1 iff clamping occurred.
REQ-024 Latency: last beat accepted at edge E0 SHALL give out_valid=1 after edge E0+3, absent stall.
REQ-025 Stall = out_valid && !out_ready; during stall all stages and the accumulator SHALL hold and in_ready SHALL be 0.
REQ-026 in_ready SHALL be !stall (combinational); a single-cycle result consumption with out_ready=1 SHALL allow a new result in the same edge without bubble.
REQ-027 out_data/out_sat SHALL stay stable while out_valid && !out_ready.
REQ-028 Cycles with no accepted beat SHALL insert bubbles; bubbles SHALL NOT alter the accumulator.
REQ-029 Single-beat groups (in_last on first beat) SHALL be legal and back-to-back at one per cycle.
REQ-030 busy SHALL be 0 only when S1, S2 invalid and no group is open.

Reset
REQ-031 rst=1 SHALL immediately clear all stage valids, accumulator, open-group flag, captured mode; out_valid=0, out_data=0, out_sat=0, busy=0; in_ready=1.
REQ-032 Reset mid-group or mid-stall SHALL discard all partial results; first beat after release starts a new group.

Verification
REQ-033 Unsigned, all lanes a=255,x=255, one beat with last -> out_data=585225, out_sat=0, out_valid 3 cycles after accept.
REQ-034 Same beat twice, last on second -> sum 1170450 clamps to out_data=1048575, out_sat=1.
REQ-035 Signed, all lanes a=0xFF(-1), x=2, one beat last -> out_data=0xFFFEE (-18), out_sat=0; signed_mode toggled on beat 2 of a 2-beat group -> both beats signed, out_data=-36 (0xFFFDC).
REQ-036 out_ready=0, three single-beat groups streamed -> first result held stable, in_ready drops once pipeline fills, no result lost or duplicated after out_ready=1; out_ready=1 throughout gives one result per cycle.
REQ-037 rst asserted after 2 beats of an open group, released, then single beat a=1,x=1 all lanes last -> out_data=9 (no residue).
